// File: rtl/isqrt_seq.sv
// Sequential integer square root: y = floor(sqrt(x)).
// Uses the restoring digit-by-digit method and produces one result bit per clock.
// Latency is fixed at W/2+1 cycles from acceptance to y_vld.
// While a result is valid, a new operand may be accepted in that same cycle.
module isqrt_seq #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [W-1:0]   x,
    output logic           y_vld,
    output logic [W/2-1:0] y,
    output logic           busy,
    output logic           x_drop
);

    localparam int HW = W / 2;
    localparam int CW = $clog2(HW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  xs;
    logic [HW+1:0] rem;
    logic [HW-1:0] root;
    logic [CW-1:0] count;

    logic [HW+1:0] rem_shift;
    logic [HW+1:0] trial;
    logic          take;
    logic [HW+1:0] rem_next;
    logic [HW-1:0] root_next;

    // One restoring step: bring down the next two operand bits and try to subtract 4*root+1.
    // The remainder never exceeds 2*root, so dropping its top two bits on the shift loses nothing.
    always_comb begin
        rem_shift = {rem[HW-1:0], xs[W-1:W-2]};
        trial     = {root, 2'b01};
        take      = (rem_shift >= trial);
        rem_next  = take ? (rem_shift - trial) : rem_shift;
        root_next = {root[HW-2:0], take};
    end

    // The control FSM, the datapath registers and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            xs     <= '0;
            rem    <= '0;
            root   <= '0;
            count  <= '0;
            y      <= '0;
            y_vld  <= 1'b0;
            x_drop <= 1'b0;
        end else begin
            y_vld  <= 1'b0;
            x_drop <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (x_vld) begin
                        xs    <= x;
                        rem   <= '0;
                        root  <= '0;
                        count <= CW'(HW);
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (x_vld) begin
                        x_drop <= 1'b1;
                    end
                    xs    <= {xs[W-3:0], 2'b00};
                    rem   <= rem_next;
                    root  <= root_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        y     <= root_next;
                        y_vld <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and randomized checks for isqrt_seq with W=32.
// Inputs change 1ns after a rising edge, and outputs are sampled at that same point.
// As a result, each sample describes the cycle that has just started.
module tb_isqrt_seq;

    logic        clk;
    logic        rst;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        x_drop;

    int checks   = 0;
    int failures = 0;
    logic [15:0] last_y = '0;

    isqrt_seq #(.W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .x_vld  (x_vld),
        .x      (x),
        .y_vld  (y_vld),
        .y      (y),
        .busy   (busy),
        .x_drop (x_drop)
    );

    // Free-running clock with a 10ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so that a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [31:0] val);
        x_vld = vld;
        x     = val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: binary search on r*r <= v, computed in 64 bits.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [16:0] lo;
        logic [16:0] hi;
        logic [16:0] mid;
        lo = 17'd0;
        hi = 17'h10000;
        while (hi - lo > 17'd1) begin
            mid = (lo + hi) >> 1;
            if (64'(mid) * 64'(mid) <= 64'(v)) lo = mid;
            else hi = mid;
        end
        return lo[15:0];
    endfunction

    // Issues one operand from idle and checks every cycle until the unit is idle again.
    task automatic run_op(input logic [31:0] val, input logic [15:0] expy);
        applyStimulus(1'b1, val);
        tick();
        applyStimulus(1'b0, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            checkOutput("busy_phase", {30'd0, busy, y_vld}, 32'd2);
            checkOutput("y_hold", 32'(y), 32'(last_y));
            checkOutput("no_drop", 32'(x_drop), 32'd0);
            tick();
        end
        checkOutput("done_vld", {30'd0, busy, y_vld}, 32'd1);
        checkOutput("result", 32'(y), 32'(expy));
        last_y = expy;
        tick();
        checkOutput("idle_after", {30'd0, busy, y_vld}, 32'd0);
        checkOutput("y_kept", 32'(y), 32'(last_y));
    endtask

    initial begin
        logic [31:0] rv;

        // Reset.
        rst = 1'b1;
        applyStimulus(1'b0, 32'd0);
        tick();
        tick();
        checkOutput("rst_y_vld", 32'(y_vld), 32'd0);
        checkOutput("rst_y", 32'(y), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_x_drop", 32'(x_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Directed single operations, including both range extremes.
        $display("[TB] directed vectors");
        run_op(32'd0, 16'd0);
        run_op(32'hFFFF_FFFF, 16'hFFFF);
        run_op(32'd1000000, 16'd1000);
        run_op(32'd999999, 16'd999);
        run_op(32'd1, 16'd1);
        run_op(32'd3, 16'd1);

        // Back-to-back: the second operand is issued in the first result's valid cycle.
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 32'd15);
        tick();
        applyStimulus(1'b0, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            checkOutput("b2b_busy1", {30'd0, busy, y_vld}, 32'd2);
            checkOutput("b2b_nodrop1", 32'(x_drop), 32'd0);
            tick();
        end
        checkOutput("b2b_vld1", {30'd0, busy, y_vld}, 32'd1);
        checkOutput("b2b_y1", 32'(y), 32'd3);
        applyStimulus(1'b1, 32'd16);
        tick();
        applyStimulus(1'b0, 32'd0);
        for (int i = 18; i <= 33; i++) begin
            checkOutput("b2b_busy2", {30'd0, busy, y_vld}, 32'd2);
            checkOutput("b2b_hold", 32'(y), 32'd3);
            checkOutput("b2b_nodrop2", 32'(x_drop), 32'd0);
            tick();
        end
        checkOutput("b2b_vld2", {30'd0, busy, y_vld}, 32'd1);
        checkOutput("b2b_y2", 32'(y), 32'd4);
        checkOutput("b2b_nodrop3", 32'(x_drop), 32'd0);
        tick();
        checkOutput("b2b_idle", {30'd0, busy, y_vld}, 32'd0);
        last_y = 16'd4;

        // A request made while busy is dropped, and the running operation is undisturbed.
        $display("[TB] rejection");
        applyStimulus(1'b1, 32'd144);
        tick();
        applyStimulus(1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drop_busy_pre", {30'd0, busy, y_vld}, 32'd2);
            tick();
        end
        applyStimulus(1'b1, 32'd7);
        tick();
        applyStimulus(1'b0, 32'd0);
        checkOutput("drop_pulse", 32'(x_drop), 32'd1);
        checkOutput("drop_still_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("drop_one_cycle", 32'(x_drop), 32'd0);
        for (int i = 7; i <= 16; i++) begin
            checkOutput("drop_busy_post", {30'd0, busy, y_vld}, 32'd2);
            tick();
        end
        checkOutput("drop_vld", {30'd0, busy, y_vld}, 32'd1);
        checkOutput("drop_y", 32'(y), 32'd12);
        last_y = 16'd12;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("drop_no_second_vld", 32'(y_vld), 32'd0);
            checkOutput("drop_y_kept", 32'(y), 32'd12);
        end

        // A reset in mid-operation abandons it.
        $display("[TB] reset during busy");
        applyStimulus(1'b1, 32'd81);
        tick();
        applyStimulus(1'b0, 32'd0);
        for (int i = 1; i <= 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_y_vld", 32'(y_vld), 32'd0);
        checkOutput("mid_rst_y", 32'(y), 32'd0);
        checkOutput("mid_rst_x_drop", 32'(x_drop), 32'd0);
        last_y = 16'd0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput("abandoned_no_vld", {30'd0, busy, y_vld}, 32'd0);
        end
        run_op(32'd49, 16'd7);

        // Randomized sweep checked against the reference model.
        $display("[TB] random sweep");
        for (int n = 0; n < 300; n++) begin
            rv = (n % 4 == 0) ? 32'($urandom_range(0, 65535)) : 32'($urandom);
            run_op(rv, ref_sqrt(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
